// File: rtl/write_to_usb_if.sv
// Wishbone master bus between the USB writer and the SDRAM controller.
interface write_to_usb_if;
  logic [31:0] data_o;
  logic        stall_o;
  logic        sdram_ack;
  logic        stb_i;
  logic        we_i;
  logic [3:0]  sel_i;
  logic        cyc_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;

  modport master (
    input  data_o, stall_o, sdram_ack,
    output stb_i, we_i, sel_i, cyc_i, addr_i, data_i
  );

  modport slave (
    output data_o, stall_o, sdram_ack,
    input  stb_i, we_i, sel_i, cyc_i, addr_i, data_i
  );
endinterface

// File: rtl/write_to_usb.sv
// Streams 16-bit result words from SDRAM (Wishbone reads) into the FX2 EP6 FIFO,
// one word at a time, committing a short packet at the end when needed.
module write_to_usb (
  input  logic        CLK,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] word_count,
  output logic        busy,
  output logic        done,
  write_to_usb_if.master wb,
  input  logic        FLAGD,
  output logic        SLWR,
  output logic        SLRD,
  output logic        SLOE,
  output logic [1:0]  FIFOADR,
  output logic        pktend,
  output logic [15:0] FDATA_out,
  output logic        FDATA_oe
);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_ACK, WAIT_FLAG, WRITE, PKTEND, DONE
  } state_t;

  state_t      state, state_nx;
  logic [31:0] base_q;
  logic [15:0] count_q;
  logic [15:0] idx_q;
  logic [15:0] buf_q;
  logic        capture;
  logic        more;
  logic        data_hi_unused;

  assign data_hi_unused = ^wb.data_o[31:16];

  assign capture = (state == FETCH && !wb.stall_o && wb.sdram_ack) ||
                   (state == WAIT_ACK && wb.sdram_ack);
  // 17-bit compare so a count of 65535 terminates cleanly
  assign more = ({1'b0, idx_q} + 17'd1) < {1'b0, count_q};

  always_ff @(posedge CLK) begin
    if (rst) begin
      state   <= IDLE;
      base_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start && word_count != 16'd0) begin
        base_q  <= base_addr;
        count_q <= word_count;
        idx_q   <= '0;
      end
      if (capture)        buf_q <= wb.data_o[15:0];
      if (state == WRITE) idx_q <= idx_q + 16'd1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (start) state_nx = (word_count != 16'd0) ? FETCH : DONE;
      FETCH:     if (!wb.stall_o) state_nx = wb.sdram_ack ? WAIT_FLAG : WAIT_ACK;
      WAIT_ACK:  if (wb.sdram_ack) state_nx = WAIT_FLAG;
      WAIT_FLAG: if (FLAGD) state_nx = WRITE;
      WRITE:     state_nx = more ? FETCH : PKTEND;
      PKTEND:    state_nx = DONE;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Outputs decode from registered state/datapath only
  always_comb begin
    busy      = (state != IDLE) && (state != DONE);
    done      = 1'b0;
    SLWR      = 1'b1;
    pktend    = 1'b1;
    FDATA_out = '0;
    FDATA_oe  = 1'b0;
    wb.cyc_i  = 1'b0;
    wb.stb_i  = 1'b0;
    wb.we_i   = 1'b0;
    wb.sel_i  = 4'b0000;
    wb.addr_i = '0;
    wb.data_i = '0;
    case (state)
      FETCH: begin
        wb.cyc_i  = 1'b1;
        wb.stb_i  = 1'b1;
        wb.sel_i  = 4'b0011;
        wb.addr_i = base_q + {16'd0, idx_q};
      end
      WAIT_ACK: begin
        wb.cyc_i  = 1'b1;
        wb.sel_i  = 4'b0011;
        wb.addr_i = base_q + {16'd0, idx_q};
      end
      WAIT_FLAG: begin
        FDATA_oe  = 1'b1;
        FDATA_out = buf_q;
      end
      WRITE: begin
        SLWR      = 1'b0;
        FDATA_oe  = 1'b1;
        FDATA_out = buf_q;
      end
      PKTEND:  pktend = (count_q[7:0] == 8'd0);
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign SLRD    = 1'b1;
  assign SLOE    = 1'b1;
  assign FIFOADR = 2'b10;

endmodule

// File: tb/tb_write_to_usb.sv
// Scoreboard bench for write_to_usb: a small SDRAM slave model plus a monitor
// that pops expected addresses, words and transfer summaries as the DUT emits them.
module tb_write_to_usb;
  logic        CLK = 1'b0;
  logic        rst, start, FLAGD;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic        busy, done, SLWR, SLRD, SLOE, pktend, FDATA_oe;
  logic [1:0]  FIFOADR;
  logic [15:0] FDATA_out;

  write_to_usb_if wb();

  write_to_usb dut (
    .CLK(CLK), .rst(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .busy(busy), .done(done), .wb(wb),
    .FLAGD(FLAGD), .SLWR(SLWR), .SLRD(SLRD), .SLOE(SLOE),
    .FIFOADR(FIFOADR), .pktend(pktend), .FDATA_out(FDATA_out),
    .FDATA_oe(FDATA_oe)
  );

  always #5 CLK = ~CLK;

  typedef struct {int words; int pkts; int was;} txn_t;

  int          checks = 0, errors = 0;
  logic [31:0] exp_addr[$];
  logic [15:0] exp_word[$];
  txn_t        exp_txn[$];

  int          ack_mode = 1, stall_budget = 0;
  bit          pending = 0, force_ack = 0;
  logic [31:0] pend_addr = '0;
  int          slwr_cnt = 0, pk_cnt = 0, acc_cnt = 0, wa_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag_err(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [15:0] word_at(input logic [31:0] a);
    return a[15:0] + 16'h008F;
  endfunction

  // SDRAM slave decides stall/ack for the coming edge, then the monitor scores
  always @(negedge CLK) begin
    wb.sdram_ack = force_ack;
    wb.stall_o   = 1'b0;
    if (rst) begin
      pending = 0;
      slwr_cnt = 0; pk_cnt = 0; acc_cnt = 0; wa_cnt = 0;
    end else begin
      if (pending) begin
        wb.sdram_ack = 1'b1;
        wb.data_o    = {16'hFFFF, word_at(pend_addr)};
        pending      = 0;
      end else if (wb.cyc_i && wb.stb_i) begin
        if (stall_budget > 0) begin
          wb.stall_o = 1'b1;
          stall_budget--;
        end else if (ack_mode == 0) begin
          wb.sdram_ack = 1'b1;
          wb.data_o    = {16'hFFFF, word_at(wb.addr_i)};
        end else begin
          pending   = 1;
          pend_addr = wb.addr_i;
        end
      end

      if (wb.cyc_i && wb.stb_i) begin
        if (exp_addr.size() == 0) flag_err("unexpected_fetch");
        else if (wb.stall_o) chk("addr_stall", wb.addr_i, exp_addr[0]);
        else begin
          chk("addr", wb.addr_i, exp_addr.pop_front());
          chk("sel_we", {27'd0, wb.sel_i, wb.we_i}, {27'd0, 4'b0011, 1'b0});
          acc_cnt++;
        end
      end
      if (wb.cyc_i && !wb.stb_i) wa_cnt++;
      if (FDATA_oe) begin
        if (exp_word.size() == 0) flag_err("unexpected_fdata");
        else if (SLWR) chk("fdata_hold", 32'(FDATA_out), 32'(exp_word[0]));
        else begin
          chk("fdata_write", 32'(FDATA_out), 32'(exp_word.pop_front()));
          chk("busy_write", 32'(busy), 32'd1);
          slwr_cnt++;
        end
      end else if (!SLWR) flag_err("slwr_without_oe");
      if (!pktend) pk_cnt++;
      if (done) begin
        chk("busy_at_done", 32'(busy), 32'd0);
        if (exp_txn.size() == 0) flag_err("unexpected_done");
        else begin
          txn_t t;
          t = exp_txn.pop_front();
          chk("slwr_pulses", 32'(slwr_cnt), 32'(t.words));
          chk("fetches", 32'(acc_cnt), 32'(t.words));
          chk("pktend_pulses", 32'(pk_cnt), 32'(t.pkts));
          chk("wait_ack_cycles", 32'(wa_cnt), 32'(t.was));
        end
        slwr_cnt = 0; pk_cnt = 0; acc_cnt = 0; wa_cnt = 0;
      end
    end
  end

  task automatic push_auto(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(base + 32'(i));
      exp_word.push_back(word_at(base + 32'(i)));
    end
  endtask

  task automatic push_txn(input int w, input int p, input int wa);
    txn_t t;
    t.words = w; t.pkts = p; t.was = wa;
    exp_txn.push_back(t);
  endtask

  task automatic do_start(input logic [31:0] b, input logic [15:0] n);
    @(negedge CLK);
    start = 1'b1; base_addr = b; word_count = n;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_txn(input int budget, output int cyc);
    cyc = 0;
    while (exp_txn.size() != 0 && cyc < budget) begin
      @(negedge CLK);
      cyc++;
    end
    if (exp_txn.size() != 0) begin
      flag_err("timeout_waiting_done");
      exp_txn.delete(); exp_addr.delete(); exp_word.delete();
    end
    chk("leftover_words", 32'(exp_word.size()), 32'd0);
    chk("leftover_addrs", 32'(exp_addr.size()), 32'd0);
    @(negedge CLK);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_strobes"}, {26'd0, SLWR, SLRD, SLOE, pktend, FIFOADR},
        {26'd0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10});
    chk({tag, "_fdata"}, {15'd0, FDATA_oe, FDATA_out}, 32'd0);
    chk({tag, "_bus"}, {25'd0, wb.cyc_i, wb.stb_i, wb.we_i, wb.sel_i}, 32'd0);
    chk({tag, "_addr"}, wb.addr_i, 32'd0);
    chk({tag, "_wdata"}, wb.data_i, 32'd0);
    chk({tag, "_busy_done"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int cyc, seen;
    rst = 1'b1; start = 1'b0; FLAGD = 1'b1; base_addr = '0; word_count = '0;
    wb.data_o = '0; wb.stall_o = 1'b0; wb.sdram_ack = 1'b0;
    repeat (2) @(negedge CLK);
    check_reset_vals("reset");
    rst = 1'b0;

    // Three words, ack one cycle after stb, short packet
    ack_mode = 1;
    exp_addr.push_back(32'h12); exp_addr.push_back(32'h13); exp_addr.push_back(32'h14);
    exp_word.push_back(16'h00A1); exp_word.push_back(16'h00A2); exp_word.push_back(16'h00A3);
    push_txn(3, 1, 3);
    do_start(32'h12, 16'd3);
    wait_txn(200, cyc);

    // Full 512-byte packet, zero-wait SDRAM: no pktend, 3 cycles per word
    ack_mode = 0;
    push_auto(32'h1000, 256); push_txn(256, 0, 0);
    do_start(32'h1000, 16'd256);
    wait_txn(2000, cyc);
    checks++;
    if (cyc > 772) begin
      errors++;
      $display("FAIL throughput: took %0d cycles, limit 772", cyc);
    end

    // Stall for 3 cycles, ack as stall drops: no WAIT_ACK cycle
    stall_budget = 3;
    push_auto(32'h200, 2); push_txn(2, 1, 0);
    do_start(32'h200, 16'd2);
    wait_txn(200, cyc);

    // FIFO full for 10 cycles in WAIT_FLAG
    FLAGD = 1'b0;
    push_auto(32'h300, 1); push_txn(1, 1, 0);
    do_start(32'h300, 16'd1);
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge CLK);
      if (FDATA_oe) seen = 1;
    end
    if (seen == 0) flag_err("wait_flag_not_reached");
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("slwr_held", 32'(SLWR), 32'd1);
      chk("fdata_held", 32'(FDATA_out), 32'h038F);
    end
    FLAGD = 1'b1;
    @(negedge CLK);
    chk("write_after_flag", 32'(SLWR), 32'd0);
    wait_txn(200, cyc);

    // Zero count: done right away, no bus cycles
    push_txn(0, 0, 0);
    do_start(32'h0, 16'd0);
    chk("zero_done", 32'(done), 32'd1);
    wait_txn(20, cyc);

    // Start while busy is ignored
    ack_mode = 1;
    push_auto(32'h500, 2); push_txn(2, 1, 2);
    do_start(32'h500, 16'd2);
    @(negedge CLK);
    do_start(32'h600, 16'd5);
    wait_txn(200, cyc);

    // Reset during WAIT_ACK of the second word of five
    push_auto(32'h40, 5); push_txn(5, 1, 5);
    do_start(32'h40, 16'd5);
    seen = (wb.cyc_i && !wb.stb_i) ? 1 : 0;
    for (int i = 0; i < 100 && seen < 2; i++) begin
      @(negedge CLK);
      if (wb.cyc_i && !wb.stb_i) seen++;
    end
    if (seen < 2) flag_err("second_wait_ack_not_reached");
    rst = 1'b1;
    @(negedge CLK);
    check_reset_vals("midreset");
    exp_addr.delete(); exp_word.delete(); exp_txn.delete();
    @(negedge CLK);
    rst = 1'b0; force_ack = 1'b1;
    @(negedge CLK);
    force_ack = 1'b0;
    chk("late_ack_ignored", {30'd0, wb.cyc_i, busy}, 32'd0);
    repeat (3) @(negedge CLK);
    push_auto(32'h80, 1); push_txn(1, 1, 1);
    do_start(32'h80, 16'd1);
    wait_txn(100, cyc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
